mem_ctrl: RTL and testbench

Byte-wide memory controller between the L1 caches and the single-port RAM/IO bus. It arbitrates per byte between data-cache byte requests and instruction-cache line fetches. The data cache always has priority. For each granted byte it drives the RAM address, data and write strobe, then returns a completion strobe one cycle later. Instruction lines are assembled into a 32-bit word, and a fetch resumes seamlessly after data-cache preemption.

---
 rtl/mem_ctrl_if.sv | 34 +++
 rtl/mem_ctrl.sv | 110 +++++++++++
 tb/tb_mem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Cache/RAM-side bus of the byte-wide memory controller.
// The slave modport is the controller's view; master is the caches/RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int LINE_BYTES = 4
);
  logic                    dc_get_en;
  logic                    dc_write_mode;
  logic [ADDR_WIDTH-1:0]   dc_addr;
  logic [7:0]              dc_data;
  logic                    dc_out_en;
  logic [7:0]              dc_content;
  logic                    io_buffer_full;
  logic                    ic_req;
  logic [ADDR_WIDTH-1:0]   ic_addr;
  logic                    ic_done;
  logic [8*LINE_BYTES-1:0] ic_data;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [ADDR_WIDTH-1:0]   mem_a;
  logic                    mem_wr;

  modport slave (
    input  dc_get_en, dc_write_mode, dc_addr, dc_data, io_buffer_full,
    input  ic_req, ic_addr, mem_din,
    output dc_out_en, dc_content, ic_done, ic_data, mem_dout, mem_a, mem_wr
  );

  modport master (
    output dc_get_en, dc_write_mode, dc_addr, dc_data, io_buffer_full,
    output ic_req, ic_addr, mem_din,
    input  dc_out_en, dc_content, ic_done, ic_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter: dcache bytes take priority over icache line fetches,
// one grant per cycle, completion reported one cycle after issue.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 18,
  parameter int LINE_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);
  localparam int LW = 8 * LINE_BYTES;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-3:0] r_line_hi;
  logic [2:0]            r_issue_cnt;
  logic [2:0]            r_recv_cnt;
  logic                  r_pend_d;
  logic                  r_pend_i;
  logic [1:0]            r_pend_idx;
  logic [LW-1:0]         r_buf;
  logic [LW-1:0]         r_ic_data;

  logic                  w_dc_io_wr;
  logic                  w_dc_grant;
  logic                  w_ic_grant;
  logic                  w_last_byte;
  logic [LW-1:0]         w_line_next;

  // Grants are suppressed while rst is low so the bus reads idle during reset.
  assign w_dc_io_wr  = bus.dc_write_mode && (bus.dc_addr[ADDR_WIDTH-1 -: 2] == 2'b11);
  assign w_dc_grant  = rst && bus.dc_get_en && !(w_dc_io_wr && bus.io_buffer_full);
  assign w_ic_grant  = rst && !w_dc_grant && (r_state == S_FETCH) && (r_issue_cnt < 3'd4);
  assign w_last_byte = r_pend_i && (r_recv_cnt == 3'd3);

  always_comb begin
    bus.mem_a    = '0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = '0;
    if (w_dc_grant) begin
      bus.mem_a    = bus.dc_addr;
      bus.mem_wr   = bus.dc_write_mode;
      bus.mem_dout = bus.dc_data;
    end else if (w_ic_grant) begin
      bus.mem_a    = {r_line_hi, r_issue_cnt[1:0]};
    end
  end

  // Buffer image including the byte arriving this cycle, so the final byte
  // lands in ic_data on the same edge that enters DONE.
  always_comb begin
    w_line_next = r_buf;
    if (r_pend_i) begin
      w_line_next[{r_pend_idx, 3'b000} +: 8] = bus.mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_line_hi   <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_pend_d    <= 1'b0;
      r_pend_i    <= 1'b0;
      r_pend_idx  <= '0;
      r_buf       <= '0;
      r_ic_data   <= '0;
    end else begin
      r_pend_d   <= w_dc_grant;
      r_pend_i   <= w_ic_grant;
      r_pend_idx <= r_issue_cnt[1:0];
      if (w_ic_grant) begin
        r_issue_cnt <= r_issue_cnt + 3'd1;
      end
      if (r_pend_i) begin
        r_buf <= w_line_next;
        if (r_recv_cnt < 3'd4) begin
          r_recv_cnt <= r_recv_cnt + 3'd1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (bus.ic_req) begin
            r_line_hi   <= bus.ic_addr[ADDR_WIDTH-1:2];
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_last_byte) begin
            r_ic_data <= w_line_next;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dc_out_en  = r_pend_d;
  assign bus.dc_content = bus.mem_din;
  assign bus.ic_done    = (r_state == S_DONE);
  assign bus.ic_data    = r_ic_data;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic checked against a byte-array memory model.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_WIDTH(18), .LINE_BYTES(4)) bus ();
  mem_ctrl #(.ADDR_WIDTH(18), .LINE_BYTES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM behind the controller, plus a preload port used while the DUT is idle.
  logic [7:0]  ram [0:262143];
  logic        pl_we = 1'b0;
  logic [17:0] pl_a  = '0;
  logic [7:0]  pl_d  = '0;
  always @(posedge clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a];
  end

  logic [7:0] sh [0:262143];  // reference memory image
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dc(input logic en, input logic wr, input logic [17:0] a,
                          input logic [7:0] d, input logic full);
    bus.dc_get_en = en; bus.dc_write_mode = wr; bus.dc_addr = a;
    bus.dc_data = d; bus.io_buffer_full = full;
  endtask

  task automatic preload(input logic [17:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    sh[a] = d;
    tick();
    pl_we = 1'b0;
  endtask

  typedef struct {
    logic        en, wr, full;
    logic [17:0] a;
    logic [7:0]  d;
    logic        exp_wr;
    logic [17:0] exp_a;
    logic [7:0]  exp_dout;
    logic        exp_oen;
    logic        chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [9];
    logic [31:0] exp_line;
    int done_c;
    int seen;

    vt[0] = '{1,0,0, 18'h00104, 8'h00, 0, 18'h00104, 8'h00, 1, 1, 8'hA5};
    vt[1] = '{1,1,0, 18'h00150, 8'h3C, 1, 18'h00150, 8'h3C, 1, 0, 8'h00};
    vt[2] = '{1,0,0, 18'h00150, 8'h00, 0, 18'h00150, 8'h00, 1, 1, 8'h3C};
    vt[3] = '{1,1,1, 18'h30002, 8'h41, 0, 18'h00000, 8'h00, 0, 0, 8'h00};
    vt[4] = '{1,1,0, 18'h30002, 8'h42, 1, 18'h30002, 8'h42, 1, 0, 8'h00};
    vt[5] = '{1,0,1, 18'h30001, 8'h00, 0, 18'h30001, 8'h00, 1, 1, 8'h5C};
    vt[6] = '{0,1,0, 18'h01234, 8'hFF, 0, 18'h00000, 8'h00, 0, 0, 8'h00};
    vt[7] = '{1,1,1, 18'h20000, 8'h77, 1, 18'h20000, 8'h77, 1, 0, 8'h00};
    vt[8] = '{1,0,0, 18'h30002, 8'h00, 0, 18'h30002, 8'h00, 1, 1, 8'h42};

    drive_dc(0, 0, '0, '0, 0);
    bus.ic_req = 1'b0; bus.ic_addr = '0;

    // reset state
    tick(); tick();
    @(negedge clk);
    chk("rst dc_out_en", 32'(bus.dc_out_en), 0);
    chk("rst ic_done", 32'(bus.ic_done), 0);
    chk("rst ic_data", bus.ic_data, 0);
    chk("rst mem_wr", 32'(bus.mem_wr), 0);
    chk("rst mem_a", 32'(bus.mem_a), 0);
    chk("rst mem_dout", 32'(bus.mem_dout), 0);
    tick();
    rst = 1'b1;
    tick();

    preload(18'h00104, 8'hA5);
    preload(18'h30001, 8'h5C);
    for (int i = 0; i < 4; i++) preload(18'h01000 + 18'(i), 8'(32'h12345678 >> (8*i)));
    for (int i = 0; i < 4; i++) preload(18'h01004 + 18'(i), 8'(32'hDEADBEEF >> (8*i)));
    preload(18'h02100, 8'h9A);
    preload(18'h02101, 8'h9B);

    // single-access vector table
    foreach (vt[i]) begin
      drive_dc(vt[i].en, vt[i].wr, vt[i].a, vt[i].d, vt[i].full);
      @(negedge clk);
      chk($sformatf("vec%0d mem_wr", i), 32'(bus.mem_wr), 32'(vt[i].exp_wr));
      chk($sformatf("vec%0d mem_a", i), 32'(bus.mem_a), 32'(vt[i].exp_a));
      chk($sformatf("vec%0d mem_dout", i), 32'(bus.mem_dout), 32'(vt[i].exp_dout));
      tick();
      drive_dc(0, 0, '0, '0, 0);
      @(negedge clk);
      chk($sformatf("vec%0d dc_out_en", i), 32'(bus.dc_out_en), 32'(vt[i].exp_oen));
      if (vt[i].chk_rd) chk($sformatf("vec%0d dc_content", i), 32'(bus.dc_content), 32'(vt[i].exp_rd));
      tick();
    end

    // back-to-back 4-byte write burst, then read-back burst
    for (int i = 0; i < 4; i++) begin
      drive_dc(1, 1, 18'h00200 + 18'(i), 8'(8'h11 * (i + 1)), 0);
      @(negedge clk);
      chk("burst wr mem_wr", 32'(bus.mem_wr), 1);
      chk("burst wr mem_a", 32'(bus.mem_a), 32'h200 + i);
      chk("burst wr dc_out_en", 32'(bus.dc_out_en), (i > 0) ? 1 : 0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_dc(1, 0, 18'h00200 + 18'(i), 8'h00, 0);
      else drive_dc(0, 0, '0, '0, 0);
      @(negedge clk);
      chk("burst rd dc_out_en", 32'(bus.dc_out_en), 1);
      if (i > 0) chk("burst rd dc_content", 32'(bus.dc_content), 32'(8'h11 * i));
      tick();
    end

    // uncontended icache fetch
    bus.ic_req = 1'b1; bus.ic_addr = 18'h01002;
    tick();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk("fetch mem_a", 32'(bus.mem_a), 32'h1000 + c - 1);
        chk("fetch mem_wr", 32'(bus.mem_wr), 0);
      end
      chk($sformatf("fetch ic_done c%0d", c), 32'(bus.ic_done), (c == 6) ? 1 : 0);
      if (c >= 6) chk("fetch ic_data", bus.ic_data, 32'h12345678);
      if (bus.ic_done) bus.ic_req = 1'b0;
      tick();
    end

    // dcache preempts a fetch for two cycles
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) begin bus.ic_req = 1'b1; bus.ic_addr = 18'h01004; end
      if (c == 3 || c == 4) drive_dc(1, 0, 18'h02100 + 18'(c - 3), 8'h00, 0);
      else drive_dc(0, 0, '0, '0, 0);
      @(negedge clk);
      case (c)
        1: chk("preempt mem_a c1", 32'(bus.mem_a), 32'h1004);
        2: chk("preempt mem_a c2", 32'(bus.mem_a), 32'h1005);
        3: chk("preempt mem_a c3", 32'(bus.mem_a), 32'h2100);
        4: chk("preempt mem_a c4", 32'(bus.mem_a), 32'h2101);
        5: chk("preempt mem_a c5", 32'(bus.mem_a), 32'h1006);
        6: chk("preempt mem_a c6", 32'(bus.mem_a), 32'h1007);
        default: ;
      endcase
      if (c >= 1 && c <= 7)
        chk($sformatf("preempt dc_out_en c%0d", c), 32'(bus.dc_out_en), (c == 4 || c == 5) ? 1 : 0);
      if (c == 4) chk("preempt dc_content c4", 32'(bus.dc_content), 32'h9A);
      if (c == 5) chk("preempt dc_content c5", 32'(bus.dc_content), 32'h9B);
      if (c >= 1) chk($sformatf("preempt ic_done c%0d", c), 32'(bus.ic_done), (c == 8) ? 1 : 0);
      if (c == 8) chk("preempt ic_data", bus.ic_data, 32'hDEADBEEF);
      if (bus.ic_done) bus.ic_req = 1'b0;
      tick();
    end

    // IO write held off by a full buffer
    for (int c = 0; c <= 5; c++) begin
      if (c <= 3) drive_dc(1, 1, 18'h30000, 8'h41, (c < 3) ? 1'b1 : 1'b0);
      else drive_dc(0, 0, '0, '0, 0);
      @(negedge clk);
      if (c <= 3) begin
        chk($sformatf("io mem_wr c%0d", c), 32'(bus.mem_wr), (c == 3) ? 1 : 0);
        chk($sformatf("io mem_a c%0d", c), 32'(bus.mem_a), (c == 3) ? 32'h30000 : 0);
        chk($sformatf("io mem_dout c%0d", c), 32'(bus.mem_dout), (c == 3) ? 32'h41 : 0);
      end
      chk($sformatf("io dc_out_en c%0d", c), 32'(bus.dc_out_en), (c == 4) ? 1 : 0);
      tick();
    end
    sh[18'h30000] = 8'h41;

    // reset aborts a fetch in flight
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin bus.ic_req = 1'b1; bus.ic_addr = 18'h01000; end
      if (c == 4) begin rst = 1'b0; bus.ic_req = 1'b0; end
      if (c == 5) rst = 1'b1;
      @(negedge clk);
      if (c == 4) begin
        chk("rstabort mem_a", 32'(bus.mem_a), 0);
        chk("rstabort mem_wr", 32'(bus.mem_wr), 0);
      end
      if (c == 5) begin
        chk("rstabort dc_out_en", 32'(bus.dc_out_en), 0);
        chk("rstabort ic_done", 32'(bus.ic_done), 0);
        chk("rstabort ic_data", bus.ic_data, 0);
      end
      tick();
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.ic_done) seen++;
      tick();
    end
    chk("rstabort no ic_done", 32'(seen), 0);
    bus.ic_req = 1'b1; bus.ic_addr = 18'h01001;
    tick();
    done_c = -1;
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clk);
      if (bus.ic_done) begin
        done_c = c;
        chk("refetch ic_data", bus.ic_data, 32'h12345678);
        bus.ic_req = 1'b0;
      end
      tick();
    end
    chk("refetch latency", 32'(done_c), 6);

    // randomized traffic against the memory-image model
    for (int a = 0; a < 256; a++) preload(18'h01000 + 18'(a), 8'($urandom));
    for (int a = 0; a < 256; a++) preload(18'h02000 + 18'(a), 8'($urandom));
    for (int a = 0; a < 4; a++) preload(18'h30000 + 18'(a), 8'($urandom));
    begin
      logic fetch_on = 1'b0;
      int   fwait = 0;
      logic prev_g = 1'b0, prev_rd = 1'b0;
      logic [7:0] prev_exp = '0;
      for (int n = 0; n < 1500; n++) begin
        logic en, wr, full, g;
        logic [17:0] a, line;
        logic [7:0] d;
        en   = ($urandom_range(0, 9) < 4);
        wr   = $urandom_range(0, 1);
        full = ($urandom_range(0, 2) == 0);
        a    = ($urandom_range(0, 3) == 0) ? 18'h30000 + 18'($urandom_range(0, 3))
                                           : 18'h02000 + 18'($urandom_range(0, 255));
        d    = 8'($urandom);
        drive_dc(en, wr, a, d, full);
        if (!fetch_on && $urandom_range(0, 7) == 0) begin
          bus.ic_addr = 18'h01000 + 18'($urandom_range(0, 255));
          bus.ic_req  = 1'b1;
          line = bus.ic_addr & ~18'h3;
          exp_line = {sh[line + 3], sh[line + 2], sh[line + 1], sh[line]};
          fetch_on = 1'b1;
          fwait = 0;
        end
        g = en && !(wr && a[17:16] == 2'b11 && full);
        @(negedge clk);
        chk("rand dc_out_en", 32'(bus.dc_out_en), 32'(prev_g));
        if (prev_g && prev_rd) chk("rand dc_content", 32'(bus.dc_content), 32'(prev_exp));
        if (g) begin
          chk("rand mem_a", 32'(bus.mem_a), 32'(a));
          chk("rand mem_wr", 32'(bus.mem_wr), 32'(wr));
        end
        if (bus.ic_done) begin
          if (fetch_on) chk("rand ic_data", bus.ic_data, exp_line);
          else chk("rand spurious ic_done", 1, 0);
          fetch_on = 1'b0;
          bus.ic_req = 1'b0;
        end else if (fetch_on) begin
          fwait++;
          if (fwait > 200) begin
            chk("rand fetch timeout", 1, 0);
            fetch_on = 1'b0;
            bus.ic_req = 1'b0;
          end
        end
        prev_g = g;
        prev_rd = !wr;
        prev_exp = sh[a];
        if (g && wr) sh[a] = d;
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
